vga_timing_gen: RTL

- Parametrised H/V video timing generator. It replaces the standalone vertical counter with a combined horizontal and vertical counter pair.
- Emits hsync, vsync, data-enable, pixel coordinates and frame/line strobes for any VGA-class mode up to 1920x1200.
- Sits between the pixel-clock domain logic and the pixel/framebuffer fetch path.
- All outputs are registered and mutually aligned.

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/mod_counter.sv | 35 +++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types, mode presets and helpers for the video timing generator.
package vga_timing_pkg;

   typedef enum logic {
      SYNC_NEG = 1'b0,
      SYNC_POS = 1'b1
   } sync_pol_e;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_t;

   typedef struct packed {
      axis_t     h;
      axis_t     v;
      sync_pol_e hs_pol;
      sync_pol_e vs_pol;
   } vga_mode_t;

   localparam vga_mode_t MODE_640X480_60 = '{
      h: '{active: 640, fp: 16, sync: 96, bp: 48},
      v: '{active: 480, fp: 10, sync: 2, bp: 33},
      hs_pol: SYNC_NEG, vs_pol: SYNC_NEG};

   localparam vga_mode_t MODE_800X600_60 = '{
      h: '{active: 800, fp: 40, sync: 128, bp: 88},
      v: '{active: 600, fp: 1, sync: 4, bp: 23},
      hs_pol: SYNC_POS, vs_pol: SYNC_POS};

   localparam vga_mode_t MODE_1280X720_60 = '{
      h: '{active: 1280, fp: 110, sync: 40, bp: 220},
      v: '{active: 720, fp: 5, sync: 5, bp: 20},
      hs_pol: SYNC_POS, vs_pol: SYNC_POS};

   // Reduced-blanking timing: positive hsync, negative vsync.
   localparam vga_mode_t MODE_1920X1200_RB = '{
      h: '{active: 1920, fp: 48, sync: 32, bp: 80},
      v: '{active: 1200, fp: 3, sync: 6, bp: 26},
      hs_pol: SYNC_POS, vs_pol: SYNC_NEG};

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with enable; wrap flags the enabled edge that returns the count to 0.
module mod_counter #(
   parameter int unsigned MOD = 2,
   parameter int unsigned W   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      wrap  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = wrap ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical video timing generator with registered, mutually aligned outputs.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter sync_pol_e   HS_POL   = SYNC_NEG,
   parameter sync_pol_e   VS_POL   = SYNC_NEG,
   parameter int unsigned CNT_W    = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] hcnt,
   output logic [CNT_W-1:0] vcnt,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line_start,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       CNT_W == 0 || CNT_W > 32 ||
       64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_params
      $error("vga_timing_gen: zero-sized region or totals do not fit in CNT_W bits");
   end

   logic [CNT_W-1:0] h_i, v_i;
   logic             h_wrap, unused_v_wrap;

   mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_hcnt (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .cnt  (h_i),
      .wrap (h_wrap)
   );

   mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_vcnt (
      .clk  (clk),
      .rst  (rst),
      .en   (en && h_wrap),
      .cnt  (v_i),
      .wrap (unused_v_wrap)
   );

   int unsigned      h_u, v_u;
   logic [CNT_W-1:0] hcnt_d, hcnt_q, vcnt_d, vcnt_q;
   logic             hsync_d, hsync_q, vsync_d, vsync_q, de_d, de_q;
   logic             line_start_d, line_start_q, frame_start_d, frame_start_q;

   assign h_u = 32'(h_i);
   assign v_u = 32'(v_i);

   // Strobes default to 0 so a held (en=0) cycle never repeats them.
   always_comb begin
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (en) begin
         hcnt_d        = h_i;
         vcnt_d        = v_i;
         de_d          = (h_u < H_ACTIVE) && (v_u < V_ACTIVE);
         hsync_d       = (h_u >= HS_START && h_u < HS_END) ? logic'(HS_POL) : ~logic'(HS_POL);
         vsync_d       = (v_u >= VS_START && v_u < VS_END) ? logic'(VS_POL) : ~logic'(VS_POL);
         line_start_d  = (h_i == '0);
         frame_start_d = (h_i == '0) && (v_i == '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         hsync_q       <= ~logic'(HS_POL);
         vsync_q       <= ~logic'(VS_POL);
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcnt        = hcnt_q;
   assign vcnt        = vcnt_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
